// File: rtl/ysyx_22050612_pkg.sv
// Shared constants for the write-back path: data/index widths and arbiter source encodings.
package ysyx_22050612_pkg;

    localparam int XLEN   = 64;
    localparam int GPR_AW = 5;

    localparam logic SRC_EXU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

endpackage

// File: rtl/ysyx_22050612_scoreboard.sv
// Per-GPR pending-write bits with one set port, one clear port and three read ports.
module ysyx_22050612_scoreboard
    import ysyx_22050612_pkg::*;
#(
    parameter int ADDR_W = GPR_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] rd0_idx,
    input  logic [ADDR_W-1:0] rd1_idx,
    input  logic [ADDR_W-1:0] rd2_idx,
    output logic              rd0_busy,
    output logic              rd1_busy,
    output logic              rd2_busy
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // x0 never becomes busy: its mask bits are tied off.
    assign set_mask[0] = 1'b0;
    assign clr_mask[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_mask
            assign set_mask[gi] = set_en && (set_idx == ADDR_W'(gi));
            assign clr_mask[gi] = clr_en && (clr_idx == ADDR_W'(gi));
        end
    endgenerate

    // Set is applied after clear so a same-edge set on the same index wins.
    assign busy_d = (busy_q & ~clr_mask) | set_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rd0_busy = busy_q[rd0_idx];
    assign rd1_busy = busy_q[rd1_idx];
    assign rd2_busy = busy_q[rd2_idx];

endmodule

// File: rtl/ysyx_22050612_wb_arbiter.sv
// Arbitrates EXU/LSU write-backs onto the single GPR write port and gates issue on pending writes.
module ysyx_22050612_wb_arbiter
    import ysyx_22050612_pkg::*;
#(
    parameter int DATA_W    = XLEN,
    parameter int ADDR_W    = GPR_AW,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ls_valid,
    output logic              ls_ready,
    input  logic [ADDR_W-1:0] ls_rd,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] iss_rs1,
    input  logic [ADDR_W-1:0] iss_rs2,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    logic              ptr_q, ptr_d;
    logic              grant_ex, grant_ls;
    logic              rf_wen_q, rf_wen_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              rs1_busy, rs2_busy, rd_busy;

    always_comb begin
        grant_ex = 1'b0;
        grant_ls = 1'b0;
        ptr_d    = ptr_q;
        if (ex_valid && ls_valid) begin
            if ((PRIO_MODE != 0) || (ptr_q == SRC_LSU)) begin
                grant_ls = 1'b1;
            end else begin
                grant_ex = 1'b1;
            end
            // The loser of a contested cycle is favoured next time.
            ptr_d = grant_ls ? SRC_EXU : SRC_LSU;
        end else begin
            grant_ex = ex_valid;
            grant_ls = ls_valid;
        end
    end

    assign ex_ready = grant_ex;
    assign ls_ready = grant_ls;

    // Writes to x0 are accepted but never reach the register file.
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_ls) begin
            rf_wen_d   = (ls_rd != '0);
            rf_waddr_d = ls_rd;
            rf_wdata_d = ls_wdata;
        end else if (grant_ex) begin
            rf_wen_d   = (ex_rd != '0);
            rf_waddr_d = ex_rd;
            rf_wdata_d = ex_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= SRC_EXU;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    assign iss_ready = ~rs1_busy & ~rs2_busy & ~rd_busy;

    ysyx_22050612_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (iss_valid && iss_ready && (iss_rd != '0)),
        .set_idx  (iss_rd),
        .clr_en   (rf_wen_q),
        .clr_idx  (rf_waddr_q),
        .rd0_idx  (iss_rs1),
        .rd1_idx  (iss_rs2),
        .rd2_idx  (iss_rd),
        .rd0_busy (rs1_busy),
        .rd1_busy (rs2_busy),
        .rd2_busy (rd_busy)
    );

endmodule

// File: tb/tb_ysyx_22050612_wb_arbiter.sv
// Directed bench: round-robin (index 0) and LSU-priority (index 1) instances share one stimulus stream.
module tb_ysyx_22050612_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_valid, ls_valid, iss_valid;
    logic [AW-1:0] ex_rd, ls_rd, iss_rd, iss_rs1, iss_rs2;
    logic [DW-1:0] ex_wdata, ls_wdata;

    logic [1:0]    ex_ready, ls_ready, iss_ready, rf_wen;
    logic [AW-1:0] rf_waddr [2];
    logic [DW-1:0] rf_wdata [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22050612_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(0)) dut_rr (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready[0]), .ex_rd(ex_rd), .ex_wdata(ex_wdata),
        .ls_valid(ls_valid), .ls_ready(ls_ready[0]), .ls_rd(ls_rd), .ls_wdata(ls_wdata),
        .iss_valid(iss_valid), .iss_ready(iss_ready[0]), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .rf_wen(rf_wen[0]), .rf_waddr(rf_waddr[0]), .rf_wdata(rf_wdata[0])
    );

    ysyx_22050612_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready[1]), .ex_rd(ex_rd), .ex_wdata(ex_wdata),
        .ls_valid(ls_valid), .ls_ready(ls_ready[1]), .ls_rd(ls_rd), .ls_wdata(ls_wdata),
        .iss_valid(iss_valid), .iss_ready(iss_ready[1]), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .rf_wen(rf_wen[1]), .rf_waddr(rf_waddr[1]), .rf_wdata(rf_wdata[1])
    );

    // Model: set of pending registers, the source owed the next contested win, and the write in flight.
    bit            m_busy   [2][NR];
    bit            m_fav_ls [2];
    bit            m_wen    [2];
    logic [AW-1:0] m_waddr  [2];
    logic [DW-1:0] m_wdata  [2];

    function automatic bit win_ls(input int m);
        if (ls_valid && !ex_valid) return 1'b1;
        if (ex_valid && !ls_valid) return 1'b0;
        if (m == 1) return 1'b1;
        return m_fav_ls[m];
    endfunction

    function automatic bit exp_iss_ready(input int m);
        return !m_busy[m][iss_rs1] && !m_busy[m][iss_rs2] && !m_busy[m][iss_rd];
    endfunction

    always @(posedge clk or posedge rst) begin : model
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                for (int r = 0; r < NR; r++) m_busy[m][r] = 1'b0;
                m_fav_ls[m] = 1'b0;
                m_wen[m]    = 1'b0;
                m_waddr[m]  = '0;
                m_wdata[m]  = '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                bit ls, issr;
                ls   = win_ls(m);
                issr = exp_iss_ready(m);
                if (m_wen[m]) m_busy[m][m_waddr[m]] = 1'b0;
                if (iss_valid && issr && iss_rd != 0) m_busy[m][iss_rd] = 1'b1;
                if (ex_valid && ls_valid) m_fav_ls[m] = !ls;
                if (ex_valid || ls_valid) begin
                    m_waddr[m] = ls ? ls_rd : ex_rd;
                    m_wdata[m] = ls ? ls_wdata : ex_wdata;
                    m_wen[m]   = (m_waddr[m] != 0);
                end else begin
                    m_wen[m] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        for (int m = 0; m < 2; m++) begin
            bit ls;
            ls = win_ls(m);
            chk($sformatf("ex_ready[%0d]", m), ex_ready[m], ex_valid && !ls);
            chk($sformatf("ls_ready[%0d]", m), ls_ready[m], ls_valid && ls);
            chk($sformatf("iss_ready[%0d]", m), iss_ready[m], exp_iss_ready(m));
            chk($sformatf("rf_wen[%0d]", m), rf_wen[m], m_wen[m]);
            if (m_wen[m]) begin
                chk($sformatf("rf_waddr[%0d]", m), rf_waddr[m], m_waddr[m]);
                chk($sformatf("rf_wdata[%0d]", m), rf_wdata[m], m_wdata[m]);
            end
        end
    end

    task automatic idle();
        ex_valid = 1'b0; ex_rd = '0; ex_wdata = '0;
        ls_valid = 1'b0; ls_rd = '0; ls_wdata = '0;
        iss_valid = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_both(input string name, input logic [1:0] act, input logic exp);
        chk({name, "[0]"}, act[0], exp);
        chk({name, "[1]"}, act[1], exp);
    endtask

    initial begin
        idle();
        @(posedge clk);
        @(negedge clk);
        lit_both("reset rf_wen", rf_wen, 1'b0);
        chk("reset rf_waddr", rf_waddr[0], 0);
        chk("reset rf_wdata", rf_wdata[0], 0);
        step();
        rst = 1'b0;
        step();

        // Lone EXU request, rd=3.
        ex_valid = 1'b1; ex_rd = 5'd3; ex_wdata = 64'h1234;
        @(negedge clk);
        lit_both("t2 ex_ready", ex_ready, 1'b1);
        step();
        idle();
        @(negedge clk);
        lit_both("t2 rf_wen", rf_wen, 1'b1);
        chk("t2 rf_waddr", rf_waddr[0], 3);
        chk("t2 rf_wdata", rf_wdata[0], 64'h1234);
        step();

        // Both sources contend for 4 cycles; EXU then gets its pending grant alone.
        for (int i = 0; i < 5; i++) begin
            ex_valid = 1'b1; ex_rd = 5'd1; ex_wdata = 64'hA1;
            ls_valid = (i < 4); ls_rd = 5'd2; ls_wdata = 64'hB2;
            @(negedge clk);
            if (i < 4) begin
                chk($sformatf("t3 rr ex_ready c%0d", i), ex_ready[0], (i % 2) == 0);
                chk($sformatf("t3 rr ls_ready c%0d", i), ls_ready[0], (i % 2) == 1);
                chk($sformatf("t6 fp ls_ready c%0d", i), ls_ready[1], 1'b1);
                chk($sformatf("t6 fp ex_ready c%0d", i), ex_ready[1], 1'b0);
            end
            if (i > 0) chk($sformatf("t3 rr rf_waddr c%0d", i), rf_waddr[0], ((i % 2) == 1) ? 1 : 2);
            step();
        end
        idle();
        @(negedge clk);
        chk("t3 rr tail rf_waddr", rf_waddr[0], 1);
        step();

        // RAW on x7 until the write-back of x7 commits.
        iss_valid = 1'b1; iss_rd = 5'd7;
        @(negedge clk);
        lit_both("t4 issue rd7", iss_ready, 1'b1);
        step();
        iss_rd = 5'd0; iss_rs1 = 5'd7;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            lit_both("t4 stall", iss_ready, 1'b0);
            step();
        end
        ex_valid = 1'b1; ex_rd = 5'd7; ex_wdata = 64'h77;
        @(negedge clk);
        lit_both("t4 stall at grant", iss_ready, 1'b0);
        step();
        ex_valid = 1'b0;
        @(negedge clk);
        lit_both("t4 commit rf_wen", rf_wen, 1'b1);
        chk("t4 commit rf_waddr", rf_waddr[0], 7);
        lit_both("t4 stall at commit", iss_ready, 1'b0);
        step();
        @(negedge clk);
        lit_both("t4 released", iss_ready, 1'b1);
        step();
        idle();

        // x0 write-back and x0 issue.
        ex_valid = 1'b1; ex_rd = 5'd0; ex_wdata = 64'hDEAD;
        @(negedge clk);
        lit_both("t5 ex_ready x0", ex_ready, 1'b1);
        step();
        idle();
        iss_valid = 1'b1;
        @(negedge clk);
        lit_both("t5 rf_wen x0", rf_wen, 1'b0);
        lit_both("t5 issue x0", iss_ready, 1'b1);
        step();
        @(negedge clk);
        lit_both("t5 x0 not busy", iss_ready, 1'b1);
        step();
        idle();

        // Write-back of non-busy x9 commits on the same edge a new rd=9 issues.
        ex_valid = 1'b1; ex_rd = 5'd9; ex_wdata = 64'h99;
        step();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd9;
        @(negedge clk);
        lit_both("t6 commit x9", rf_wen, 1'b1);
        chk("t6 commit waddr", rf_waddr[0], 9);
        lit_both("t6 issue rd9", iss_ready, 1'b1);
        step();
        iss_rd = 5'd0; iss_rs1 = 5'd9;
        @(negedge clk);
        lit_both("t6 busy9 kept", iss_ready, 1'b0);
        step();
        idle();
        ex_valid = 1'b1; ex_rd = 5'd9; ex_wdata = 64'h9A;
        step();
        idle();
        step();
        iss_rs1 = 5'd9;
        @(negedge clk);
        lit_both("t6 busy9 cleared", iss_ready, 1'b1);
        step();
        idle();

        // Reset while x5 is pending and a write is registered.
        iss_valid = 1'b1; iss_rd = 5'd5;
        step();
        idle();
        ex_valid = 1'b1; ex_rd = 5'd6; ex_wdata = 64'h66;
        step();
        idle();
        iss_rs1 = 5'd5;
        #1;
        lit_both("t1 pre-reset rf_wen", rf_wen, 1'b1);
        lit_both("t1 pre-reset busy5", iss_ready, 1'b0);
        rst = 1'b1;
        #1;
        lit_both("t1 reset rf_wen", rf_wen, 1'b0);
        lit_both("t1 reset busy5", iss_ready, 1'b1);
        step();
        rst = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd5; iss_rs1 = 5'd5; iss_rs2 = 5'd6;
        @(negedge clk);
        lit_both("t1 after release", iss_ready, 1'b1);
        step();
        idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
